// File: rtl/mosby_bus_pkg.sv
// Shared definitions for the CPU bus responder: FSM encoding, page numbers and the error read value.
package mosby_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INT  = 2'd1,
        ST_EXT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] ZERO_PAGE  = 8'h00;
    localparam logic [7:0] STACK_PAGE = 8'h01;
    localparam logic [7:0] RDATA_ERR  = 8'hFF;

    // Zero page and stack page live in the internal RAM; everything else goes off-chip.
    function automatic logic is_internal(input logic [15:0] addr);
        return (addr[15:8] == ZERO_PAGE) || (addr[15:8] == STACK_PAGE);
    endfunction

endpackage

// File: rtl/resp_ram.sv
// 512x8 single-port synchronous RAM backing the zero page and stack page.
module resp_ram (
    input  logic       clk_1,
    input  logic       we,
    input  logic [8:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] mem [512];

    // NOTE: no reset on the array or its read port, so this maps onto a RAM macro rather than flops.
    always_ff @(posedge clk_1) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/bus_responder.sv
// Target end of the CPU address/data bus: zero/stack pages from internal RAM,
// all other addresses via a req/ack external port guarded by a timeout.
module bus_responder
    import mosby_bus_pkg::*;
#(
    parameter int unsigned INT_WAIT = 1,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk_1,
    input  logic        rst,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] address,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdy,
    output logic        ext_req,
    output logic        ext_rw,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        bus_err
);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [7:0]  rdata_next;
    logic        rdy_next, ext_req_next, ext_rw_next, bus_err_next;
    logic [15:0] ext_addr_next;
    logic [7:0]  ext_wdata_next;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_dout;

    // The RAM reads the live address while idle so read data is ready for a zero-wait access.
    assign ram_addr = (state == ST_IDLE) ? address[8:0] : ext_addr[8:0];

    resp_ram u_ram (
        .clk_1 (clk_1),
        .we    (ram_we),
        .addr  (ram_addr),
        .din   (ext_wdata),
        .dout  (ram_dout)
    );

    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rdata     <= 8'h00;
            rdy       <= 1'b0;
            ext_req   <= 1'b0;
            ext_rw    <= 1'b1;
            ext_addr  <= 16'h0000;
            ext_wdata <= 8'h00;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rdata     <= rdata_next;
            rdy       <= rdy_next;
            ext_req   <= ext_req_next;
            ext_rw    <= ext_rw_next;
            ext_addr  <= ext_addr_next;
            ext_wdata <= ext_wdata_next;
            bus_err   <= bus_err_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_next     = state;
        cnt_next       = cnt;
        rdata_next     = rdata;
        rdy_next       = 1'b0;
        ext_req_next   = ext_req;
        ext_rw_next    = ext_rw;
        ext_addr_next  = ext_addr;
        ext_wdata_next = ext_wdata;
        bus_err_next   = bus_err;
        ram_we         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    ext_addr_next  = address;
                    ext_rw_next    = rw;
                    ext_wdata_next = wdata;
                    if (is_internal(address)) begin
                        state_next = ST_INT;
                        cnt_next   = 8'(INT_WAIT);
                    end else begin
                        state_next   = ST_EXT;
                        ext_req_next = 1'b1;
                        cnt_next     = 8'(TIMEOUT - 1);
                    end
                end
            end
            ST_INT: begin
                if (cnt != 8'd0) begin
                    cnt_next = cnt - 8'd1;
                end else begin
                    if (ext_rw) rdata_next = ram_dout;
                    else        ram_we     = 1'b1;
                    state_next = ST_DONE;
                    rdy_next   = 1'b1;
                end
            end
            ST_EXT: begin
                // An ack on the expiry edge takes priority over the timeout.
                if (ext_ack) begin
                    if (ext_rw) rdata_next = ext_rdata;
                    ext_req_next = 1'b0;
                    state_next   = ST_DONE;
                    rdy_next     = 1'b1;
                end else if (cnt == 8'd0) begin
                    if (ext_rw) rdata_next = RDATA_ERR;
                    bus_err_next = 1'b1;
                    ext_req_next = 1'b0;
                    state_next   = ST_DONE;
                    rdy_next     = 1'b1;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: expected rdata is queued per access and checked on each rdy pulse.
module tb_bus_responder;

    logic        clk_1 = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b1;
    logic [15:0] address = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        rdy;
    logic        ext_req;
    logic        ext_rw;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack = 1'b0;
    logic [7:0]  ext_rdata = '0;
    logic        bus_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  model_rdata = 8'h00;
    logic        prev_rdy = 1'b0;

    bus_responder #(.INT_WAIT(1), .TIMEOUT(16)) dut (
        .clk_1     (clk_1),
        .rst       (rst),
        .req       (req),
        .rw        (rw),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .rdy       (rdy),
        .ext_req   (ext_req),
        .ext_rw    (ext_rw),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk_1 = ~clk_1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: every rdy pulse consumes one queued expectation.
    always @(negedge clk_1) begin
        if (rdy) begin
            check("rdy_width", {31'd0, prev_rdy}, 32'd0);
            if (exp_q.size() == 0) begin
                check("rdy_unexpected", {31'd0, rdy}, 32'd0);
            end else begin
                check("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_rdy = rdy;
    end

    // One access from the IDLE state; ack_after=0 means the external side never acks.
    task automatic do_access(input string tag, input logic [15:0] a, input logic r,
                             input logic [7:0] wd, input logic [7:0] exp_rd,
                             input int ack_after, input logic [7:0] ack_data,
                             input logic pulse_req, input int exp_lat, input int exp_hi);
        int   lat;
        int   hi;
        logic stable;
        address = a;
        rw      = r;
        wdata   = wd;
        req     = 1'b1;
        if (r) model_rdata = exp_rd;
        exp_q.push_back(model_rdata);
        @(posedge clk_1);
        #1;
        req    = 1'b0;
        hi     = 0;
        lat    = 0;
        stable = 1'b1;
        if (ext_req) begin
            hi++;
            if (ext_addr !== a || ext_rw !== r || ext_wdata !== wd) stable = 1'b0;
        end
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            ext_ack   = (ack_after == k);
            ext_rdata = ack_data;
            req       = pulse_req && (k == 5);
            address   = 16'h0010;
            @(posedge clk_1);
            #1;
            ext_ack = 1'b0;
            req     = 1'b0;
            if (rdy) lat = k;
            if (ext_req) begin
                hi++;
                if (ext_addr !== a || ext_rw !== r || ext_wdata !== wd) stable = 1'b0;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_ext_req_cycles"}, hi, exp_hi);
        check({tag, "_ext_stable"}, {31'd0, stable}, 32'd1);
        @(posedge clk_1);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdy"}, {31'd0, rdy}, 32'd0);
        check({tag, "_rdata"}, {24'd0, rdata}, 32'h00);
        check({tag, "_ext_req"}, {31'd0, ext_req}, 32'd0);
        check({tag, "_ext_rw"}, {31'd0, ext_rw}, 32'd1);
        check({tag, "_ext_addr"}, {16'd0, ext_addr}, 32'h0000);
        check({tag, "_ext_wdata"}, {24'd0, ext_wdata}, 32'h00);
        check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        #12;
        check_reset_values("por");
        @(negedge clk_1);
        rst = 1'b1;
        @(posedge clk_1);
        #1;

        // Internal RAM: write then read back, two edges from sample to rdy.
        do_access("wr_0042", 16'h0042, 1'b0, 8'h5A, 8'h00, 0, 8'h00, 1'b0, 2, 0);
        do_access("rd_0042", 16'h0042, 1'b1, 8'h00, 8'h5A, 0, 8'h00, 1'b0, 2, 0);

        // Bit 8 must select between the two pages.
        do_access("wr_01ff", 16'h01FF, 1'b0, 8'hA5, 8'h00, 0, 8'h00, 1'b0, 2, 0);
        do_access("wr_00ff", 16'h00FF, 1'b0, 8'h11, 8'h00, 0, 8'h00, 1'b0, 2, 0);
        do_access("rd_01ff", 16'h01FF, 1'b1, 8'h00, 8'hA5, 0, 8'h00, 1'b0, 2, 0);
        do_access("rd_00ff", 16'h00FF, 1'b1, 8'h00, 8'h11, 0, 8'h00, 1'b0, 2, 0);

        // External read acked on the third cycle, and an external write.
        do_access("rd_8000", 16'h8000, 1'b1, 8'h00, 8'h3C, 3, 8'h3C, 1'b0, 3, 3);
        check("rd_8000_bus_err", {31'd0, bus_err}, 32'd0);
        do_access("wr_1234", 16'h1234, 1'b0, 8'h99, 8'h00, 2, 8'hEE, 1'b0, 2, 2);

        // Ack exactly on the expiry edge wins; a req pulse during EXT is ignored.
        do_access("rd_a000_late", 16'hA000, 1'b1, 8'h00, 8'h77, 16, 8'h77, 1'b1, 16, 16);
        check("late_ack_bus_err", {31'd0, bus_err}, 32'd0);
        repeat (4) @(posedge clk_1);
        #1;

        // Timeout on a read, then bus_err must stick across a good access.
        do_access("rd_c000_to", 16'hC000, 1'b1, 8'h00, 8'hFF, 0, 8'h00, 1'b0, 16, 16);
        check("timeout_bus_err", {31'd0, bus_err}, 32'd1);
        do_access("rd_0042_b", 16'h0042, 1'b1, 8'h00, 8'h5A, 0, 8'h00, 1'b0, 2, 0);
        check("sticky_bus_err", {31'd0, bus_err}, 32'd1);

        // Reset in the middle of an external access.
        address = 16'h9000;
        rw      = 1'b1;
        req     = 1'b1;
        @(posedge clk_1);
        #1;
        req = 1'b0;
        repeat (4) @(posedge clk_1);
        #1;
        check("abort_ext_req_before", {31'd0, ext_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("abort");
        model_rdata = 8'h00;
        @(negedge clk_1);
        rst = 1'b1;
        @(posedge clk_1);
        #1;
        do_access("rd_0042_post", 16'h0042, 1'b1, 8'h00, 8'h5A, 0, 8'h00, 1'b0, 2, 0);

        repeat (3) @(posedge clk_1);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
